// File: rtl/ct_sync_fifo.sv
// Single-clock valid/ready FIFO: a DEPTH-1 entry RAM feeding a registered first-word-fall-through
// output stage, with occupancy count and programmable almost-full flag.
module ct_sync_fifo #(
  parameter int unsigned WIDTH        = 256,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_almost_full
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned RAMDEPTH = DEPTH - 1;

  localparam logic [ADDR_WIDTH:0]   LevelFull  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LevelAfull = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   LevelOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrLast    = ADDR_WIDTH'(RAMDEPTH - 1);

  logic [WIDTH-1:0]      mem_q [RAMDEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  ready_q, ready_d;
  logic                  afull_q, afull_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;

  logic push, pop, ram_empty, load_slot, ram_we;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PtrLast) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    push        = i_valid & ready_q;
    pop         = out_valid_q & i_ready;
    // RAM holds everything except the word sitting in the output register.
    ram_empty   = (level_q == {{ADDR_WIDTH{1'b0}}, out_valid_q});
    load_slot   = ~out_valid_q | pop;
    ram_we      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (load_slot) begin
      if (!ram_empty) begin
        out_data_d  = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = ptr_inc(rd_ptr_q);
        ram_we      = push;
      end else if (push) begin
        // Empty RAM: the new word bypasses straight into the output register.
        out_data_d  = i_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      ram_we = push;
    end

    if (ram_we) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    ready_d = (level_d != LevelFull);
    afull_d = (level_d >= LevelAfull);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ready_q     <= 1'b0;
      afull_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ready_q     <= ready_d;
      afull_q     <= afull_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage is deliberately not reset; pointers and level guard against stale reads.
  always_ff @(posedge clk) begin
    if (ram_we && rst_n) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_ready       = ready_q;
  assign o_data        = out_data_q;
  assign o_valid       = out_valid_q;
  assign o_level       = level_q;
  assign o_almost_full = afull_q;

endmodule

// File: tb/tb_ct_sync_fifo.sv
// Self-checking bench for ct_sync_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_ct_sync_fifo;

  localparam int unsigned WIDTH  = 256;
  localparam int unsigned AW     = 5;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned AFULL  = 28;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic [AW:0]      o_level;
  logic             o_almost_full;

  ct_sync_fifo #(
    .WIDTH       (WIDTH),
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(AFULL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_level      (o_level),
    .o_almost_full(o_almost_full)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the FIFO contents as a plain queue.
  logic [WIDTH-1:0] m_q[$];
  logic             m_ready = 1'b0;
  logic             m_afull = 1'b0;
  int               pop_cnt = 0;

  always @(posedge clk) begin
    logic m_push, m_pop;
    if (!rst_n) begin
      m_q.delete();
      m_ready = 1'b0;
      m_afull = 1'b0;
    end else begin
      m_push = i_valid && m_ready;
      m_pop  = (m_q.size() > 0) && i_ready;
      if (m_pop) begin
        void'(m_q.pop_front());
        pop_cnt++;
      end
      if (m_push) m_q.push_back(i_data);
      m_ready = (m_q.size() != DEPTH);
      m_afull = (m_q.size() >= AFULL);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", WIDTH'(o_valid), WIDTH'(m_q.size() > 0));
      if (m_q.size() > 0) check("data", o_data, m_q[0]);
      check("level", WIDTH'(o_level), WIDTH'(m_q.size()));
      check("ready", WIDTH'(o_ready), WIDTH'(m_ready));
      check("afull", WIDTH'(o_almost_full), WIDTH'(m_afull));
    end
  end

  // Called at a negedge; drives inputs and returns at the following negedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(negedge clk);
  endtask

  initial begin
    int cycles;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_level", WIDTH'(o_level), '0);
    check("rst_ready", WIDTH'(o_ready), '0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);
    check("ready_after_rst", WIDTH'(o_ready), WIDTH'(1));

    // Single push with immediate consumption.
    step(1'b1, WIDTH'(8'hA5), 1'b1);
    check("a5_valid", WIDTH'(o_valid), WIDTH'(1));
    check("a5_data", o_data, WIDTH'(8'hA5));
    check("a5_level", WIDTH'(o_level), WIDTH'(1));
    step(1'b0, '0, 1'b1);
    check("a5_level_after", WIDTH'(o_level), '0);
    check("a5_valid_after", WIDTH'(o_valid), '0);

    // Fill to full with the consumer stalled.
    for (int k = 0; k < 32; k++) begin
      step(1'b1, WIDTH'(k), 1'b0);
      if (k == 26) check("afull_27", WIDTH'(o_almost_full), '0);
      if (k == 27) check("afull_28", WIDTH'(o_almost_full), WIDTH'(1));
      if (k == 30) check("ready_31", WIDTH'(o_ready), WIDTH'(1));
    end
    check("full_ready", WIDTH'(o_ready), '0);
    check("full_level", WIDTH'(o_level), WIDTH'(32));
    step(1'b1, WIDTH'(16'hDEAD), 1'b0);
    check("overflow_level", WIDTH'(o_level), WIDTH'(32));
    check("stall_head", o_data, '0);

    // One pop from full, then drain.
    step(1'b0, '0, 1'b1);
    check("pop_ready", WIDTH'(o_ready), WIDTH'(1));
    check("pop_level", WIDTH'(o_level), WIDTH'(31));
    for (int k = 1; k < 32; k++) begin
      check("drain_data", o_data, WIDTH'(k));
      step(1'b0, '0, 1'b1);
    end
    check("drain_empty", WIDTH'(o_valid), '0);

    // Sustained streaming.
    for (int k = 0; k < 100; k++) begin
      step(1'b1, WIDTH'(1000 + k), 1'b1);
      check("stream_level", WIDTH'(o_level), WIDTH'(1));
      check("stream_data", o_data, WIDTH'(1000 + k));
    end
    step(1'b0, '0, 1'b1);

    // Reset mid-operation.
    for (int k = 0; k < 10; k++) step(1'b1, WIDTH'(500 + k), 1'b0);
    check("pre_rst_level", WIDTH'(o_level), WIDTH'(10));
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    check("mid_rst_valid", WIDTH'(o_valid), '0);
    check("mid_rst_level", WIDTH'(o_level), '0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);
    check("mid_rst_ready", WIDTH'(o_ready), WIDTH'(1));
    step(1'b1, WIDTH'(8'h77), 1'b0);
    check("post_rst_data", o_data, WIDTH'(8'h77));
    step(1'b0, '0, 1'b1);

    // Random traffic.
    pop_cnt = 0;
    cycles  = 0;
    while (pop_cnt < 10000 && cycles < 60000) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)));
      cycles++;
    end
    check("rand_done", WIDTH'(pop_cnt >= 10000), WIDTH'(1));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ct_sync_fifo.md
Name: ct_sync_fifo

Overview:
- Single-clock valid/ready FIFO for links where producer and consumer share one clock.
- Drop-in same-clock counterpart of the dual-clock crossing. The interconnect generator inserts it instead of the crossing when both endpoints share a clock domain, so the same handshake semantics hold on both sides.
- Adds an occupancy count and a programmable almost-full flag for upstream throttling.
- Output is registered, first-word-fall-through.

Parameters:
- WIDTH, 256, data word width in bits.
- ADDR_WIDTH, 5, log2 of storage depth. DEPTH = 2**ADDR_WIDTH entries total, output register included.
- AFULL_THRESH, 28, o_almost_full asserts when occupancy >= AFULL_THRESH. Legal range 1..DEPTH.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_data  in  WIDTH  write data.
- i_valid  in  1  write request.
- o_ready  out  1  FIFO can accept a word this cycle.
- o_data  out  WIDTH  head-of-queue data, registered.
- o_valid  out  1  o_data holds a valid word.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- o_almost_full  out  1  o_level >= AFULL_THRESH.

Behaviour:
- Push = i_valid & o_ready. Pop = o_valid & i_ready. Neither has any other qualifier.
- Storage:
  - DEPTH-1 entry RAM plus one output register; o_data driven only from the output register.
  - RAM write and read pointers are ADDR_WIDTH-bit binary and wrap modulo DEPTH-1 entries.
  - Alternatively, the full DEPTH entry RAM may feed a prefetching output register, provided total capacity stays exactly DEPTH.
- Latency:
  - A word pushed at cycle N into an empty FIFO gives o_valid=1 with that word at cycle N+1.
  - No combinational path from i_valid/i_data to o_valid/o_data.
- Order: strict FIFO. No word is dropped, duplicated or reordered.
- o_data stays stable while o_valid=1 and i_ready=0.
- o_level:
  - Registered; level_next = level + push - pop.
  - Push and pop in the same cycle leave level unchanged.
- o_ready:
  - Registered: o_ready <= (level_next != DEPTH).
  - When full (o_ready=0), a pop raises o_ready on the next cycle. The word slot freed by a pop cannot be refilled in the same cycle.
  - No combinational path from i_ready to o_ready.
- Simultaneous push and pop:
  - At level 1 with the output register occupied: the pushed word enters the output register (or RAM) and o_valid stays 1 with no bubble.
  - At any level, throughput is 1 word/cycle sustained.
- o_almost_full: registered, equals (level_next >= AFULL_THRESH).
- i_valid while o_ready=0: ignored. Data is not written. The producer holds it per protocol.
- Reset:
  - While rst_n=0 at a clock edge: o_valid=0, o_ready=0, o_level=0, o_almost_full=0, o_data=0, pointers=0.
  - First edge with rst_n=1 sets o_ready=1.
  - Reset mid-operation discards all contents; no partial words survive.
- RAM contents are not reset. Stale RAM data is never presented with o_valid=1.

Test Plan:
- Reset then single push of 0xA5 at cycle N, i_ready=1 -> o_valid=1 with o_data=0xA5 at N+1; o_level 1 at N+1, 0 at N+2 after the pop.
- i_ready=0, push 32 words 0..31 back-to-back (defaults) -> o_ready falls the cycle after the 32nd push; o_level=32; o_almost_full rises the cycle after the 28th push; a 33rd attempted word is not stored.
- From full, one pop -> o_ready=1 the next cycle; o_level=31; drain yields 0..31 in order and then o_valid=0.
- Continuous i_valid=1 and i_ready=1 for 100 cycles with incrementing data -> one word per cycle out in order; o_level constant at 1; no bubbles.
- Random i_valid/i_ready (50%) over 10k words -> scoreboard matches exactly; o_level always equals pushes minus pops; o_data stable while stalled.
- Fill 10 words, assert rst_n=0 for 1 cycle -> o_valid=0, o_level=0 next edge; o_ready=1 one edge after release; the next pushed word is the first one output.
